// File: rtl/branch_history_table.sv
// Bimodal branch predictor: a flop-based table of 2-bit saturating counters
// indexed by PC[INDEX_BITS+1:2]. The fetch side reads a prediction with zero
// latency; the EX side returns the resolved outcome together with the
// prediction bit that travelled down the pipeline, which trains the table,
// raises a mispredict flush request and feeds two saturating statistics
// counters.
module branch_history_table #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] CTR_INIT   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if_i,
    input  logic        is_B_type_if_i,
    output logic        B_type_prediction_result_o,
    input  logic        update_valid_ex_i,
    input  logic [31:0] update_pc_ex_i,
    input  logic        update_taken_ex_i,
    input  logic        update_prediction_ex_i,
    input  logic        PL_stall,
    output logic        mispredict_ex_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispredict_cnt_o
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    logic [1:0]            ctr [DEPTH];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic                  upd;
    logic                  mispredicted;
    logic [31:0]           branch_cnt_q;
    logic [31:0]           mispredict_cnt_q;
    logic                  unused_pc_bits;

    assign rd_idx = pc_if_i[INDEX_BITS+1:2];
    assign wr_idx = update_pc_ex_i[INDEX_BITS+1:2];

    // Byte-offset and upper PC bits never select a table entry.
    assign unused_pc_bits = ^{pc_if_i[31:INDEX_BITS+2], pc_if_i[1:0],
                              update_pc_ex_i[31:INDEX_BITS+2], update_pc_ex_i[1:0]};

    // A branch held in EX by a stall trains only on the cycle it is released.
    assign upd          = update_valid_ex_i & ~PL_stall & ~rst;
    assign mispredicted = update_taken_ex_i ^ update_prediction_ex_i;

    // Prediction reads the pre-update counter; a same-cycle write is not bypassed.
    always_comb begin
        B_type_prediction_result_o = is_B_type_if_i & ctr[rd_idx][1];
    end

    // Flush request uses the carried prediction bit, not the current table.
    always_comb begin
        mispredict_ex_o = update_valid_ex_i & ~PL_stall & mispredicted;
    end

    // Counter table: bulk reset to CTR_INIT, saturating train on each update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (upd) begin
            if (update_taken_ex_i) begin
                if (ctr[wr_idx] != 2'b11) begin
                    ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
                end
            end else begin
                if (ctr[wr_idx] != 2'b00) begin
                    ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
                end
            end
        end
    end

    // Resolved-branch and mispredict statistics, both saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (upd) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredicted && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed self-checking bench for branch_history_table: training, saturation,
// aliasing, stall handling, same-cycle hazard, mid-run reset and statistics
// counter saturation. Expected values are hand-computed below each step.
module tb_branch_history_table;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if_i;
    logic        is_B_type_if_i;
    logic        B_type_prediction_result_o;
    logic        update_valid_ex_i;
    logic [31:0] update_pc_ex_i;
    logic        update_taken_ex_i;
    logic        update_prediction_ex_i;
    logic        PL_stall;
    logic        mispredict_ex_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    int checkCount = 0;
    int errorCount = 0;

    branch_history_table #(
        .INDEX_BITS(6),
        .CTR_INIT  (2'b01)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .pc_if_i                   (pc_if_i),
        .is_B_type_if_i            (is_B_type_if_i),
        .B_type_prediction_result_o(B_type_prediction_result_o),
        .update_valid_ex_i         (update_valid_ex_i),
        .update_pc_ex_i            (update_pc_ex_i),
        .update_taken_ex_i         (update_taken_ex_i),
        .update_prediction_ex_i    (update_prediction_ex_i),
        .PL_stall                  (PL_stall),
        .mispredict_ex_o           (mispredict_ex_o),
        .branch_cnt_o              (branch_cnt_o),
        .mispredict_cnt_o          (mispredict_cnt_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch and return the combinational prediction.
    task automatic fetchPredict(input logic [31:0] pc, output logic pred);
        pc_if_i        = pc;
        is_B_type_if_i = 1'b1;
        #1;
        pred = B_type_prediction_result_o;
    endtask

    // Present one resolved branch for a single unstalled cycle.
    task automatic applyStimulus(input logic [31:0] pc, input logic taken,
                                 input logic pred);
        update_valid_ex_i      = 1'b1;
        update_pc_ex_i         = pc;
        update_taken_ex_i      = taken;
        update_prediction_ex_i = pred;
        step();
        update_valid_ex_i      = 1'b0;
    endtask

    logic p;

    initial begin
        rst                    = 1'b1;
        pc_if_i                = '0;
        is_B_type_if_i         = 1'b0;
        update_valid_ex_i      = 1'b0;
        update_pc_ex_i         = '0;
        update_taken_ex_i      = 1'b0;
        update_prediction_ex_i = 1'b0;
        PL_stall               = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        checkOutput("reset_branch_cnt", branch_cnt_o, 32'd0);
        checkOutput("reset_mispredict_cnt", mispredict_cnt_o, 32'd0);
        checkOutput("reset_mispredict", {31'd0, mispredict_ex_o}, 32'd0);
        fetchPredict(32'h100, p);
        checkOutput("reset_pred_0x100", {31'd0, p}, 32'd0);

        // Training: two taken resolutions of 0x100, both predicted not-taken (idx0: 1->2->3)
        update_valid_ex_i      = 1'b1;
        update_pc_ex_i         = 32'h100;
        update_taken_ex_i      = 1'b1;
        update_prediction_ex_i = 1'b0;
        #1;
        checkOutput("train_mispredict_1", {31'd0, mispredict_ex_o}, 32'd1);
        step();
        checkOutput("train_mispredict_2", {31'd0, mispredict_ex_o}, 32'd1);
        step();
        update_valid_ex_i = 1'b0;
        fetchPredict(32'h100, p);
        checkOutput("train_pred_0x100", {31'd0, p}, 32'd1);
        is_B_type_if_i = 1'b0;
        #1;
        checkOutput("not_btype_pred", {31'd0, B_type_prediction_result_o}, 32'd0);
        checkOutput("train_branch_cnt", branch_cnt_o, 32'd2);
        checkOutput("train_mispredict_cnt", mispredict_cnt_o, 32'd2);

        // Saturation on 0x200 (same entry, idx0 starting at 3): 5 taken keep it at 3
        for (int i = 0; i < 5; i++) applyStimulus(32'h200, 1'b1, 1'b1);
        fetchPredict(32'h200, p);
        checkOutput("sat_pred_after_taken", {31'd0, p}, 32'd1);
        applyStimulus(32'h200, 1'b0, 1'b1);
        fetchPredict(32'h200, p);
        checkOutput("sat_pred_ctr2", {31'd0, p}, 32'd1);
        applyStimulus(32'h200, 1'b0, 1'b0);
        applyStimulus(32'h200, 1'b0, 1'b0);
        fetchPredict(32'h200, p);
        checkOutput("sat_pred_ctr0", {31'd0, p}, 32'd0);
        checkOutput("sat_branch_cnt", branch_cnt_o, 32'd10);
        checkOutput("sat_mispredict_cnt", mispredict_cnt_o, 32'd3);

        // Aliasing: 0x004 and 0x104 share idx1, 0x008 (idx2) untouched
        applyStimulus(32'h004, 1'b1, 1'b0);
        fetchPredict(32'h104, p);
        checkOutput("alias_pred_0x104", {31'd0, p}, 32'd1);
        applyStimulus(32'h104, 1'b1, 1'b1);
        fetchPredict(32'h004, p);
        checkOutput("alias_pred_0x004", {31'd0, p}, 32'd1);
        fetchPredict(32'h008, p);
        checkOutput("alias_pred_0x008", {31'd0, p}, 32'd0);

        // Stall: held taken update at 0x040 (idx16, ctr 1) trains once on release
        update_valid_ex_i      = 1'b1;
        update_pc_ex_i         = 32'h040;
        update_taken_ex_i      = 1'b1;
        update_prediction_ex_i = 1'b0;
        PL_stall               = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("stall_mispredict_%0d", i), {31'd0, mispredict_ex_o}, 32'd0);
            step();
        end
        PL_stall = 1'b0;
        #1;
        checkOutput("stall_release_mispredict", {31'd0, mispredict_ex_o}, 32'd1);
        step();
        update_valid_ex_i = 1'b0;
        checkOutput("stall_branch_cnt", branch_cnt_o, 32'd13);
        checkOutput("stall_mispredict_cnt", mispredict_cnt_o, 32'd5);
        fetchPredict(32'h040, p);
        checkOutput("stall_pred_ctr2", {31'd0, p}, 32'd1);
        applyStimulus(32'h040, 1'b0, 1'b1);
        fetchPredict(32'h040, p);
        checkOutput("stall_pred_ctr1", {31'd0, p}, 32'd0);

        // Same-cycle hazard on 0x300 (idx0, raised from 0 to 1 first)
        applyStimulus(32'h300, 1'b1, 1'b0);
        fetchPredict(32'h300, p);
        update_valid_ex_i      = 1'b1;
        update_pc_ex_i         = 32'h300;
        update_taken_ex_i      = 1'b1;
        update_prediction_ex_i = 1'b0;
        #1;
        checkOutput("hazard_pred_same_cycle", {31'd0, B_type_prediction_result_o}, 32'd0);
        step();
        update_valid_ex_i = 1'b0;
        #1;
        checkOutput("hazard_pred_next_cycle", {31'd0, B_type_prediction_result_o}, 32'd1);
        checkOutput("hazard_branch_cnt", branch_cnt_o, 32'd16);
        checkOutput("hazard_mispredict_cnt", mispredict_cnt_o, 32'd8);

        // Reset mid-run with a concurrent taken update to 0x008 that must be dropped
        rst                    = 1'b1;
        update_valid_ex_i      = 1'b1;
        update_pc_ex_i         = 32'h008;
        update_taken_ex_i      = 1'b1;
        update_prediction_ex_i = 1'b0;
        #1;
        checkOutput("rst_mispredict_comb", {31'd0, mispredict_ex_o}, 32'd1);
        step();
        rst               = 1'b0;
        update_valid_ex_i = 1'b0;
        #1;
        checkOutput("rst_branch_cnt", branch_cnt_o, 32'd0);
        checkOutput("rst_mispredict_cnt", mispredict_cnt_o, 32'd0);
        fetchPredict(32'h300, p);
        checkOutput("rst_pred_0x300", {31'd0, p}, 32'd0);
        fetchPredict(32'h004, p);
        checkOutput("rst_pred_0x004", {31'd0, p}, 32'd0);
        applyStimulus(32'h008, 1'b0, 1'b0);
        fetchPredict(32'h008, p);
        checkOutput("rst_update_dropped_0x008", {31'd0, p}, 32'd0);
        checkOutput("rst_branch_cnt_after", branch_cnt_o, 32'd1);

        // Mispredict counter saturation at all-ones
        force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_cnt_q;
        #1;
        applyStimulus(32'h00C, 1'b1, 1'b0);
        checkOutput("stat_sat_mispredict_cnt", mispredict_cnt_o, 32'hFFFF_FFFF);
        checkOutput("stat_sat_branch_cnt", branch_cnt_o, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
